// File: rtl/rv_lsu.sv
// rv_lsu: multi-cycle load/store unit for a word-wide memory with a req/ack handshake.
// Optional macro LSU_MEM_BE_EN adds o_mem_be so sub-word stores skip the RMW read.
module rv_lsu #(
  parameter int XLEN   = 32,
  parameter int ADDR_W = 32,
  localparam int NB    = XLEN / 8,
  localparam int OFF_W = $clog2(NB)
) (
  input  logic                    i_clk,
  input  logic                    i_rst,
  input  logic                    i_req_valid,
  output logic                    o_req_ready,
  input  logic                    i_req_we,
  input  logic [1:0]              i_req_size,
  input  logic                    i_req_unsigned,
  input  logic [ADDR_W-1:0]       i_req_addr,
  input  logic [XLEN-1:0]         i_req_wdata,
  output logic                    o_resp_valid,
  output logic [XLEN-1:0]         o_resp_rdata,
  output logic                    o_resp_fault,
  output logic                    o_mem_req,
  output logic                    o_mem_we,
  output logic [ADDR_W-OFF_W-1:0] o_mem_addr,
  output logic [XLEN-1:0]         o_mem_wdata,
`ifdef LSU_MEM_BE_EN
  output logic [NB-1:0]           o_mem_be,
`endif
  input  logic [XLEN-1:0]         i_mem_rdata,
  input  logic                    i_mem_ack
);

  // state | meaning
  // IDLE  | waiting for a request
  // RD    | reading the target word (load, or first half of RMW store)
  // WR    | writing the full word
  // RESP  | one-cycle response pulse
  typedef enum logic [1:0] {IDLE, RD, WR, RESP} state_t;

  localparam logic [1:0] FULL_SZ = 2'(OFF_W);

  state_t                    r_state;
  logic                      r_we;
  logic [1:0]                r_size;
  logic                      r_uns;
  logic [OFF_W-1:0]          r_off;
  logic [XLEN-1:0]           r_wdata;
  logic                      r_mem_req;
  logic                      r_mem_we;
  logic [ADDR_W-OFF_W-1:0]   r_mem_addr;
  logic [XLEN-1:0]           r_mem_wdata;
  logic                      r_resp_valid;
  logic [XLEN-1:0]           r_resp_rdata;
  logic                      r_resp_fault;

  logic [OFF_W-1:0]          w_req_off;
  logic [3:0]                w_align;
  logic                      w_fault;
  logic                      w_full;
  logic [OFF_W+2:0]          w_sh;
  logic [XLEN-1:0]           w_lmask;
  logic [XLEN-1:0]           w_smask;
  logic [XLEN-1:0]           w_shifted;
  logic [XLEN-1:0]           w_load;
  logic [XLEN-1:0]           w_merged;
  logic                      w_msb;

  assign w_req_off = i_req_addr[OFF_W-1:0];
  assign w_align   = (4'd1 << i_req_size) - 4'd1;
  assign w_fault   = ((4'(w_req_off) & w_align) != 4'd0) ||
                     ((i_req_size == 2'd3) && (XLEN == 32));
  assign w_full    = (i_req_size == FULL_SZ);
  assign w_sh      = {r_off, 3'b000};

  // Lane mask for the registered size drives both load extension and store merge.
  always_comb begin
    w_lmask   = '1;
    w_msb     = 1'b0;
    w_shifted = i_mem_rdata >> w_sh;
    case (r_size)
      2'd0: begin w_lmask = XLEN'(8'hFF);         w_msb = w_shifted[7];  end
      2'd1: begin w_lmask = XLEN'(16'hFFFF);      w_msb = w_shifted[15]; end
      2'd2: begin w_lmask = XLEN'(32'hFFFF_FFFF); w_msb = w_shifted[31]; end
      default: ;
    endcase
    w_load   = (w_shifted & w_lmask) | ((!r_uns && w_msb) ? ~w_lmask : '0);
    w_smask  = w_lmask << w_sh;
    w_merged = (i_mem_rdata & ~w_smask) | ((r_wdata << w_sh) & w_smask);
  end

`ifdef LSU_MEM_BE_EN
  logic [NB-1:0]   r_mem_be;
  logic [NB-1:0]   w_be_base;
  logic [NB-1:0]   w_be_lanes;
  logic [XLEN-1:0] w_req_wsh;

  always_comb begin
    case (i_req_size)
      2'd0:    w_be_base = NB'(8'h01);
      2'd1:    w_be_base = NB'(8'h03);
      2'd2:    w_be_base = NB'(8'h0F);
      default: w_be_base = NB'(8'hFF);
    endcase
  end
  assign w_be_lanes = w_be_base << w_req_off;
  assign w_req_wsh  = i_req_wdata << {w_req_off, 3'b000};
  assign o_mem_be   = r_mem_be;
`endif

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state      <= IDLE;
      r_we         <= 1'b0;
      r_size       <= 2'd0;
      r_uns        <= 1'b0;
      r_off        <= '0;
      r_wdata      <= '0;
      r_mem_req    <= 1'b0;
      r_mem_we     <= 1'b0;
      r_mem_addr   <= '0;
      r_mem_wdata  <= '0;
      r_resp_valid <= 1'b0;
      r_resp_rdata <= '0;
      r_resp_fault <= 1'b0;
`ifdef LSU_MEM_BE_EN
      r_mem_be     <= '0;
`endif
    end else begin
      r_resp_valid <= 1'b0;
      case (r_state)
        IDLE: begin
          if (i_req_valid) begin
            r_we       <= i_req_we;
            r_size     <= i_req_size;
            r_uns      <= i_req_unsigned;
            r_off      <= w_req_off;
            r_wdata    <= i_req_wdata;
            r_mem_addr <= i_req_addr[ADDR_W-1:OFF_W];
            if (w_fault) begin
              r_state      <= RESP;
              r_resp_valid <= 1'b1;
              r_resp_fault <= 1'b1;
              r_resp_rdata <= '0;
            end else if (!i_req_we) begin
              r_state   <= RD;
              r_mem_req <= 1'b1;
              r_mem_we  <= 1'b0;
            end else if (w_full) begin
              r_state     <= WR;
              r_mem_req   <= 1'b1;
              r_mem_we    <= 1'b1;
              r_mem_wdata <= i_req_wdata;
`ifdef LSU_MEM_BE_EN
              r_mem_be    <= '1;
`endif
            end else begin
`ifdef LSU_MEM_BE_EN
              r_state     <= WR;
              r_mem_req   <= 1'b1;
              r_mem_we    <= 1'b1;
              r_mem_wdata <= w_req_wsh;
              r_mem_be    <= w_be_lanes;
`else
              r_state   <= RD;
              r_mem_req <= 1'b1;
              r_mem_we  <= 1'b0;
`endif
            end
          end
        end
        RD: begin
          if (i_mem_ack) begin
            if (!r_we) begin
              r_state      <= RESP;
              r_mem_req    <= 1'b0;
              r_resp_valid <= 1'b1;
              r_resp_fault <= 1'b0;
              r_resp_rdata <= w_load;
            end else begin
              r_state     <= WR;
              r_mem_we    <= 1'b1;
              r_mem_wdata <= w_merged;
            end
          end
        end
        WR: begin
          if (i_mem_ack) begin
            r_state      <= RESP;
            r_mem_req    <= 1'b0;
            r_mem_we     <= 1'b0;
            r_resp_valid <= 1'b1;
            r_resp_fault <= 1'b0;
            r_resp_rdata <= '0;
          end
        end
        default: begin
          r_state      <= IDLE;
          r_resp_fault <= 1'b0;
        end
      endcase
    end
  end

  assign o_req_ready  = (r_state == IDLE) && !i_rst;
  assign o_resp_valid = r_resp_valid;
  assign o_resp_rdata = r_resp_rdata;
  assign o_resp_fault = r_resp_fault;
  assign o_mem_req    = r_mem_req;
  assign o_mem_we     = r_mem_we;
  assign o_mem_addr   = r_mem_addr;
  assign o_mem_wdata  = r_mem_wdata;

endmodule
